mem_sram_stage: RTL
===================

MEM_SRAM_STAGE -- requirements
Module: mem_sram_stage

Interface
REQ-001 Parameter: BASE_ADDR, default 1024, byte address mapped to SRAM halfword 0.
REQ-002 Parameter: WAIT_CYCLES, default 2, cycles each halfword SRAM access occupies; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: alu_res  input  32  byte address from the execute stage.
REQ-006 Port: st_val  input  32  store data from the execute stage, after forwarding.
REQ-007 Port: mem_r_en, mem_w_en  input  1 each  load and store requests.
REQ-008 Port: ready  output  1  high when the pipeline may advance; low means freeze every earlier stage.
REQ-009 Port: mem_rdata  output  32  load result.
REQ-010 Port: sram_addr  output  18  halfword address.
REQ-011 Port: sram_wdata  output  16  write data.
REQ-012 Port: sram_rdata  input  16  read data.
REQ-013 Port: sram_we_n, sram_oe_n  output  1 each  active-low write and output enables.

Function
REQ-014 States SHALL be IDLE, RD_LO, RD_HI, WR_LO, WR_HI and DONE.
REQ-015 Halfword base SHALL be hb = ((alu_res - BASE_ADDR) >> 2) << 1, truncated to 18 bits; out-of-range addresses wrap modulo 2^18 without error.
REQ-016 In IDLE, mem_r_en=1 SHALL move the block to RD_LO on the next edge; otherwise mem_w_en=1 SHALL move it to WR_LO; otherwise it SHALL stay in IDLE.
REQ-017 If mem_r_en and mem_w_en are both high, the read SHALL win and no write SHALL occur.
REQ-018 ready SHALL be combinational: 1 in DONE, or in IDLE with no request; 0 otherwise, including the IDLE request cycle.
REQ-019 Each of RD_LO, RD_HI, WR_LO and WR_HI SHALL last exactly WAIT_CYCLES cycles, counted by a wait counter cleared on every state entry.
REQ-020 In RD_LO and RD_HI, sram_addr SHALL be hb and hb+1 respectively, with sram_oe_n=0 and sram_we_n=1.
REQ-021 sram_rdata SHALL be captured into mem_rdata[15:0] on the last RD_LO cycle and into mem_rdata[31:16] on the last RD_HI cycle.
REQ-022 In WR_LO and WR_HI, sram_addr SHALL be hb and hb+1, with sram_wdata = st_val[15:0] and st_val[31:16] respectively, sram_we_n=0 and sram_oe_n=1.
REQ-023 In all other states, sram_we_n and sram_oe_n SHALL both be 1, and sram_addr and sram_wdata SHALL hold their last values.
REQ-024 DONE SHALL last one cycle (ready=1) and then return to IDLE.
REQ-025 A request still asserted in the IDLE cycle after DONE SHALL be treated as a new access.
REQ-026 Latency from the request-accept edge SHALL be 2*WAIT_CYCLES+1 cycles to ready=1; mem_rdata SHALL be valid in DONE and held until the next read capture.
REQ-027 alu_res, st_val and the request lines are only sampled in IDLE; the upstream stage holds them stable while ready=0.
REQ-028 mem_rdata SHALL NOT change during writes.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE, wait counter=0, mem_rdata=0, sram_addr=0, sram_wdata=0 and sram_we_n=sram_oe_n=1.
REQ-030 Reset asserted mid-access SHALL abort the access; a partially written word remains partially written.
REQ-031 After rst deasserts, the first edge SHALL behave as IDLE.

Structure
REQ-032 The state enum, the default BASE_ADDR and WAIT_CYCLES, and the SRAM address and data widths SHALL live in the shared pipeline package.
REQ-033 The wait counter SHALL be one sub-module, sram_wait_counter, with clear, enable and terminal-count output.
REQ-034 Everything else SHALL be a single FSM inside mem_sram_stage.

Verification
REQ-035 Read test: with W=2 and sram_rdata modelled so halfword 4=0x1234 and halfword 5=0xABCD, a read at alu_res=0x408 SHALL give sram_addr 4,4,5,5, then ready=1 on cycle 5 with mem_rdata=0xABCD1234.
REQ-036 Write test: a write at 0x400 with st_val=0xDEADBEEF SHALL give we_n=0 for 2 cycles at addr 0 with data 0xBEEF, then 2 cycles at addr 1 with data 0xDEAD, then ready=1.
REQ-037 Both-enables test: mem_r_en=mem_w_en=1 at 0x404 SHALL perform a read only, with sram_we_n=1 throughout.
REQ-038 Back-to-back test: a read, then a write held after DONE, SHALL accept the write in the following IDLE cycle, keeping ready=0 from that cycle.
REQ-039 Reset test: rst during the second RD_HI cycle SHALL give state=IDLE, sram_oe_n=1 and mem_rdata=0 immediately (asynchronous), with ready=1 once rst is low and no request is present.
REQ-040 Wrap test: alu_res=0x3FC (below BASE_ADDR) SHALL give sram_addr=0x3FFFE then 0x3FFFF.

Source files
------------

// File: rtl/mem_sram_stage_pkg.sv
// Shared pipeline package for the SRAM memory stage.
// Holds the FSM states, default timing and the SRAM bus widths.
package mem_sram_stage_pkg;

  localparam int unsigned BASE_ADDR_DEF   = 1024;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned SRAM_AW         = 18;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned WCNT_W          = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } sram_state_t;

  // Byte address to halfword base of a 32-bit word; wraps silently.
  function automatic logic [SRAM_AW-1:0] hw_base(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return SRAM_AW'(((addr - base) >> 2) << 1);
  endfunction

endpackage

// File: rtl/mem_sram_stage_wait_counter.sv
// Wait-state counter for one halfword SRAM access.
// o_tc flags the last cycle of the access.
module sram_wait_counter
  import mem_sram_stage_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [WCNT_W-1:0] LAST = WCNT_W'(WAIT_CYCLES - 1);

  logic [WCNT_W-1:0] r_cnt;

  // Count cycles spent in the current access state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/mem_sram_stage.sv
// Memory stage driving a 16-bit asynchronous SRAM.
// Each 32-bit access is split into low and high halfword cycles.
module mem_sram_stage
  import mem_sram_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        st_val,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  output logic               ready,
  output logic [31:0]        mem_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  sram_state_t r_state;
  sram_state_t w_next;

  logic               w_tc;
  logic               w_busy;
  logic               w_clr;
  logic [SRAM_AW-1:0] w_hb;
  logic [SRAM_AW-1:0] w_addr_nx;
  logic [SRAM_DW-1:0] w_wdata_nx;
  logic               w_we_n_nx;
  logic               w_oe_n_nx;

  logic [SRAM_AW-1:0] r_addr;
  logic [SRAM_DW-1:0] r_wdata;
  logic               r_we_n;
  logic               r_oe_n;
  logic [31:0]        r_rdata;

  assign w_hb = hw_base(alu_res, 32'(BASE_ADDR));

  assign w_busy = (r_state == RD_LO) || (r_state == RD_HI) ||
                  (r_state == WR_LO) || (r_state == WR_HI);

  // Leaving an access state or sitting outside one restarts the count.
  assign w_clr = !w_busy || w_tc;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_clr),
    .i_en (w_busy),
    .o_tc (w_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state; a read wins over a simultaneous write.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (mem_r_en)      w_next = RD_LO;
        else if (mem_w_en) w_next = WR_LO;
      end
      RD_LO: if (w_tc) w_next = RD_HI;
      RD_HI: if (w_tc) w_next = DONE;
      WR_LO: if (w_tc) w_next = WR_HI;
      WR_HI: if (w_tc) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // SRAM bus values for the state being entered; idle states hold the bus.
  always_comb begin
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    w_we_n_nx  = 1'b1;
    w_oe_n_nx  = 1'b1;
    unique case (w_next)
      RD_LO: begin
        w_addr_nx = w_hb;
        w_oe_n_nx = 1'b0;
      end
      RD_HI: begin
        w_addr_nx = w_hb + 1'b1;
        w_oe_n_nx = 1'b0;
      end
      WR_LO: begin
        w_addr_nx  = w_hb;
        w_wdata_nx = st_val[15:0];
        w_we_n_nx  = 1'b0;
      end
      WR_HI: begin
        w_addr_nx  = w_hb + 1'b1;
        w_wdata_nx = st_val[31:16];
        w_we_n_nx  = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered SRAM bus so strobes are glitch free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
    end else begin
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
      r_we_n  <= w_we_n_nx;
      r_oe_n  <= w_oe_n_nx;
    end
  end

  // Capture each read halfword on the last cycle of its access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_tc && (r_state == RD_LO)) begin
      r_rdata[15:0] <= sram_rdata;
    end else if (w_tc && (r_state == RD_HI)) begin
      r_rdata[31:16] <= sram_rdata;
    end
  end

  assign ready = (r_state == DONE) ||
                 ((r_state == IDLE) && !mem_r_en && !mem_w_en);

  assign mem_rdata  = r_rdata;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_we_n  = r_we_n;
  assign sram_oe_n  = r_oe_n;

endmodule
